// File: rtl/pm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pm_sequencer
//  Purpose  : Program-memory instruction sequencer.  Steps each instruction
//             through FETCH -> READ -> EXEC -> (WAIT) -> WB and advances the
//             program counter on leaving WB.  An instruction can hold in WAIT
//             while the synchronized SW8 switch matches its argument level.
//             In single-step mode a step button edge releases one instruction.
//
//             Every output is a flop loaded from a decode of the current
//             state.  Each strobe therefore appears one clock after its state
//             is entered.  The PC register advances on the WB->FETCH edge,
//             which is the same edge that raises wb_en_o, so pc_o already
//             holds the next index while wb_en_o is high.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock         in   rising-edge clock
//    nReset        in   asynchronous active-low reset
//    sw_go_i       in   raw SW8 level (asynchronous)
//    wait_req_i    in   current instruction is wait-on-switch
//    wait_level_i  in   hold while synchronized SW8 equals this level
//    step_mode_i   in   1 = single-step mode
//    step_i        in   raw step button (asynchronous)
//    pc_o          out  current instruction index
//    fetch_en_o    out  fetch phase strobe
//    regrd_en_o    out  register-read phase strobe
//    exec_en_o     out  execute phase strobe
//    wb_en_o       out  write-back phase strobe
//    waiting_o     out  held in WAIT
//    wrap_o        out  one-cycle pulse when pc_o wraps to 0
// ============================================================================
module pm_sequencer #(
   parameter int PC_W        = 5,
   parameter int PROG_LEN    = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic            Clock,
   input  logic            nReset,
   input  logic            sw_go_i,
   input  logic            wait_req_i,
   input  logic            wait_level_i,
   input  logic            step_mode_i,
   input  logic            step_i,
   output logic [PC_W-1:0] pc_o,
   output logic            fetch_en_o,
   output logic            regrd_en_o,
   output logic            exec_en_o,
   output logic            wb_en_o,
   output logic            waiting_o,
   output logic            wrap_o
);

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_FETCH = 3'd1,
      S_READ  = 3'd2,
      S_EXEC  = 3'd3,
      S_WAIT  = 3'd4,
      S_WB    = 3'd5
   } state_t;

   localparam logic [PC_W-1:0] c_PC_LAST = PC_W'(PROG_LEN - 1);

   state_t                 r_state;
   state_t                 w_next;
   logic [SYNC_STAGES-1:0] r_go_sync;
   logic [SYNC_STAGES-1:0] r_step_sync;
   logic                   r_step_prev;
   logic [PC_W-1:0]        r_pc;
   logic                   r_fetch;
   logic                   r_regrd;
   logic                   r_exec;
   logic                   r_wb;
   logic                   r_waiting;
   logic                   r_wrap;

   logic                   w_go;
   logic                   w_step;
   logic                   w_step_rise;
   logic                   w_fetch;
   logic                   w_regrd;
   logic                   w_exec;
   logic                   w_wb;
   logic                   w_waiting;

   // ---------------------------------------------------------------------
   // Switch synchronizers and step edge detector
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_go_sync   <= '0;
         r_step_sync <= '0;
         r_step_prev <= 1'b0;
      end else begin
         r_go_sync   <= {r_go_sync[SYNC_STAGES-2:0], sw_go_i};
         r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step_i};
         r_step_prev <= w_step;
      end
   end

   assign w_go   = r_go_sync[SYNC_STAGES-1];
   assign w_step = r_step_sync[SYNC_STAGES-1];
   // One-cycle pulse; it is only consumed in FETCH, so an edge seen in any
   // other state simply expires instead of being remembered.
   assign w_step_rise = w_step & ~r_step_prev;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= S_START;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_next    = r_state;
      w_fetch   = 1'b0;
      w_regrd   = 1'b0;
      w_exec    = 1'b0;
      w_wb      = 1'b0;
      w_waiting = 1'b0;
      case (r_state)
         S_START: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            w_fetch = 1'b1;
            if (!step_mode_i || w_step_rise) begin
               w_next = S_READ;
            end
         end
         S_READ: begin
            w_regrd = 1'b1;
            w_next  = S_EXEC;
         end
         S_EXEC: begin
            w_exec = 1'b1;
            if (wait_req_i && (w_go == wait_level_i)) begin
               w_next = S_WAIT;
            end else begin
               w_next = S_WB;
            end
         end
         S_WAIT: begin
            // wait_req_i is deliberately not looked at here: once held, only
            // the switch moving away from the argument level releases us.
            w_waiting = 1'b1;
            if (w_go != wait_level_i) begin
               w_next = S_WB;
            end
         end
         S_WB: begin
            w_wb   = 1'b1;
            w_next = S_FETCH;
         end
         default: begin
            w_next = S_START;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registered outputs and program counter
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_pc      <= '0;
         r_fetch   <= 1'b0;
         r_regrd   <= 1'b0;
         r_exec    <= 1'b0;
         r_wb      <= 1'b0;
         r_waiting <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_fetch   <= w_fetch;
         r_regrd   <= w_regrd;
         r_exec    <= w_exec;
         r_wb      <= w_wb;
         r_waiting <= w_waiting;
         r_wrap    <= 1'b0;
         if (r_state == S_WB) begin
            if (r_pc == c_PC_LAST) begin
               r_pc   <= '0;
               r_wrap <= 1'b1;
            end else begin
               r_pc <= r_pc + 1'b1;
            end
         end
      end
   end

   assign pc_o       = r_pc;
   assign fetch_en_o = r_fetch;
   assign regrd_en_o = r_regrd;
   assign exec_en_o  = r_exec;
   assign wb_en_o    = r_wb;
   assign waiting_o  = r_waiting;
   assign wrap_o     = r_wrap;

endmodule
`default_nettype wire
